display_scan_controller: RTL and testbench

Sequences the shared binary-to-BCD converter and time-multiplexes its three decimal digits onto one seven-segment digit decoder. It accepts 8-bit values from the top level (switch input or serial decode output) and issues one-cycle conversion requests to the converter. It double-buffers the returned digits and scans hundreds/tens/ones with per-digit dwell and leading-zero blanking. `digit_out` feeds the decimal seven-segment decoder; `digit_select` drives the digit commons.

---
 rtl/display_scan_controller.sv | 150 +++++++++++++++
 tb/tb_display_scan_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Drives the shared binary-to-BCD converter and time-multiplexes its three
// result digits onto one seven-segment decoder with leading-zero blanking.
module display_scan_controller #(
   parameter int DWELL_CYCLES = 1024,
   parameter int DWELL_WIDTH  = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  value,
   input  logic        value_valid,
   output logic        conv_start,
   output logic [7:0]  conv_binary,
   input  logic        conv_done,
   input  logic [11:0] conv_digits,
   output logic [3:0]  digit_out,
   output logic [2:0]  digit_select,
   output logic        blank,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t                 state;
   logic                   pending;
   logic [7:0]             pending_value;
   logic                   staged;
   logic [11:0]            staging;
   logic [11:0]            display;
   logic [DWELL_WIDTH-1:0] dwell_count;

   logic                   capture;
   logic                   terminal;
   logic                   wrap;
   logic [2:0]             select_next;
   logic [11:0]            display_next;
   logic [3:0]             digit_next;
   logic                   blank_next;

   assign capture = (state == WAIT) && conv_done;

   // busy is registered, so each branch sets it from the state/pending pair
   // it is about to leave behind.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= 1'b0;
         pending_value <= 8'd0;
         conv_start    <= 1'b0;
         conv_binary   <= 8'd0;
         busy          <= 1'b0;
      end else begin
         conv_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (value_valid) begin
                  conv_binary <= value;
                  pending     <= 1'b0;
                  conv_start  <= 1'b1;
                  busy        <= 1'b1;
                  state       <= START;
               end else if (pending) begin
                  conv_binary <= pending_value;
                  pending     <= 1'b0;
                  conv_start  <= 1'b1;
                  busy        <= 1'b1;
                  state       <= START;
               end else begin
                  busy <= 1'b0;
               end
            end
            START: begin
               busy  <= 1'b1;
               state <= WAIT;
               if (value_valid) begin
                  pending       <= 1'b1;
                  pending_value <= value;
               end
            end
            WAIT: begin
               busy <= 1'b1;
               if (value_valid) begin
                  pending       <= 1'b1;
                  pending_value <= value;
               end
               // A request arriving with conv_done stays pending behind the one launched now.
               if (conv_done) begin
                  if (pending) begin
                     conv_binary <= pending_value;
                     conv_start  <= 1'b1;
                     state       <= START;
                     if (!value_valid) begin
                        pending <= 1'b0;
                     end
                  end else begin
                     state <= IDLE;
                     busy  <= value_valid;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= pending;
            end
         endcase
      end
   end

   // Next-value view of the scan so digit, select and blank register together.
   always_comb begin
      terminal     = (dwell_count == DWELL_WIDTH'(DWELL_CYCLES - 1));
      wrap         = terminal && digit_select[2];
      select_next  = terminal ? {digit_select[1:0], digit_select[2]} : digit_select;
      display_next = (wrap && staged) ? staging : display;
      digit_next   = display_next[3:0];
      blank_next   = 1'b0;
      if (select_next[1]) begin
         digit_next = display_next[7:4];
         blank_next = (display_next[11:8] == 4'd0) && (display_next[7:4] == 4'd0);
      end else if (select_next[2]) begin
         digit_next = display_next[11:8];
         blank_next = (display_next[11:8] == 4'd0);
      end
   end

   // A capture coinciding with a wrap re-arms staged; the wrap used the old copy.
   always_ff @(posedge clock) begin
      if (reset) begin
         dwell_count  <= '0;
         digit_select <= 3'b001;
         display      <= 12'd0;
         staging      <= 12'd0;
         staged       <= 1'b0;
         digit_out    <= 4'd0;
         blank        <= 1'b0;
      end else begin
         dwell_count  <= terminal ? '0 : dwell_count + DWELL_WIDTH'(1);
         digit_select <= select_next;
         display      <= display_next;
         digit_out    <= digit_next;
         blank        <= blank_next;
         if (capture) begin
            staging <= conv_digits;
            staged  <= 1'b1;
         end else if (wrap) begin
            staged <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller: converter model, conversion
// request queue and a per-cycle scan/display monitor.
module tb_display_scan_controller;

   localparam int DWELL = 4;
   localparam int FRAME = 3 * DWELL;

   typedef struct packed {
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
      logic       bh;
      logic       bt;
   } disp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  value;
   logic        value_valid;
   logic        conv_start;
   logic [7:0]  conv_binary;
   logic        conv_done;
   logic [11:0] conv_digits;
   logic [3:0]  digit_out;
   logic [2:0]  digit_select;
   logic        blank;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int epoch = 0;
   int conv_delay = 5;
   int force_seq = 0;
   logic [11:0] force_digits = 12'd0;
   bit force_accept = 1'b0;
   int last_done_cyc = -1;

   logic [7:0] exp_conv[$];
   disp_t      disp_q[$];
   int         act_q[$];

   display_scan_controller #(.DWELL_CYCLES(DWELL), .DWELL_WIDTH(2)) dut (
      .clock(clock), .reset(reset), .value(value), .value_valid(value_valid),
      .conv_start(conv_start), .conv_binary(conv_binary), .conv_done(conv_done),
      .conv_digits(conv_digits), .digit_out(digit_out), .digit_select(digit_select),
      .blank(blank), .busy(busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic disp_t mk(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                input logic bh, input logic bt);
      disp_t d;
      d.h = h; d.t = t; d.o = o; d.bh = bh; d.bt = bt;
      return d;
   endfunction

   function automatic logic [11:0] bcd(input logic [7:0] v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor and converter model share one negedge process to avoid ordering races.
   initial begin : monitor
      bit         armed;
      int         cnt;
      int         force_ack;
      int         op_epoch;
      int         slot;
      logic [7:0] operand;
      disp_t      cur;
      logic [2:0] esel;
      logic [3:0] edig;
      logic       eblank;
      armed = 1'b0; cnt = 0; force_ack = 0; op_epoch = 0; operand = 8'd0;
      cur = mk(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
      conv_done = 1'b0;
      conv_digits = 12'd0;
      forever begin
         @(negedge clock);
         conv_done = 1'b0;
         if (reset) begin
            armed = 1'b1;
            epoch++;
            exp_conv.delete();
            disp_q.delete();
            act_q.delete();
            cur = mk(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
         end else if (armed) begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  conv_done = 1'b1;
                  conv_digits = bcd(operand);
                  if (op_epoch == epoch) begin
                     checkOutput("conv_binary_hold", {24'd0, conv_binary}, {24'd0, operand});
                     act_q.push_back((cyc + 1) / FRAME + 1);
                     last_done_cyc = cyc + 1;
                  end
               end
            end
            if (force_seq != force_ack) begin
               force_ack = force_seq;
               conv_done = 1'b1;
               conv_digits = force_digits;
               if (force_accept) begin
                  act_q.push_back((cyc + 1) / FRAME + 1);
                  last_done_cyc = cyc + 1;
               end
            end
            if (conv_start) begin
               if (exp_conv.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL conv_start_unexpected: got request with conv_binary=%0d, expected none (cycle %0d)",
                           conv_binary, cyc);
               end else begin
                  checkOutput("conv_start_binary", {24'd0, conv_binary}, {24'd0, exp_conv.pop_front()});
               end
               if (conv_delay > 0) begin
                  cnt = conv_delay;
                  operand = conv_binary;
                  op_epoch = epoch;
               end
            end
            while (act_q.size() > 0 && (cyc / FRAME) >= act_q[0]) begin
               void'(act_q.pop_front());
               if (disp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL display_capture: got an accepted capture, expected no pending display entry");
               end else begin
                  cur = disp_q.pop_front();
               end
            end
            slot = (cyc / DWELL) % 3;
            case (slot)
               0:       begin esel = 3'b001; edig = cur.o; eblank = 1'b0;    end
               1:       begin esel = 3'b010; edig = cur.t; eblank = cur.bt;  end
               default: begin esel = 3'b100; edig = cur.h; eblank = cur.bh;  end
            endcase
            checkOutput("scan_sel_digit_blank", {24'd0, digit_select, digit_out, blank},
                        {24'd0, esel, edig, eblank});
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] v, input bit exp_start, input bit exp_disp, input disp_t d);
      if (exp_start) exp_conv.push_back(v);
      if (exp_disp)  disp_q.push_back(d);
      value = v;
      value_valid = 1'b1;
      @(posedge clock); #1;
      value_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic forceDone(input logic [11:0] digits, input bit accept);
      force_digits = digits;
      force_accept = accept;
      force_seq++;
      @(posedge clock); #1;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got busy still high after 200 cycles, expected idle", name);
      end else begin
         checkOutput(name, cyc, last_done_cyc);
      end
   endtask

   task automatic waitWrapMinus1();
      int n;
      n = 0;
      while ((cyc % FRAME) != FRAME - 1 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      checkOutput("wrap_align", cyc % FRAME, FRAME - 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      disp_t none;
      none = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      reset = 1'b1;
      value = 8'd0;
      value_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      checkOutput("reset_busy", {31'd0, busy}, 0);
      checkOutput("reset_conv_start", {31'd0, conv_start}, 0);
      checkOutput("reset_conv_binary", {24'd0, conv_binary}, 0);
      checkOutput("reset_select", {29'd0, digit_select}, 32'b001);
      checkOutput("reset_digit", {28'd0, digit_out}, 0);
      checkOutput("reset_blank", {31'd0, blank}, 0);
      waitCycles(2 * FRAME);

      $display("[TB] single conversion of 157");
      applyStimulus(8'd157, 1'b1, 1'b1, mk(4'd1, 4'd5, 4'd7, 1'b0, 1'b0));
      checkOutput("busy_rise", {31'd0, busy}, 1);
      checkOutput("conv_start_pulse", {31'd0, conv_start}, 1);
      waitIdle("busy_fall_157");
      waitCycles(3 * FRAME);

      $display("[TB] leading zeros: 5 then 40");
      applyStimulus(8'd5, 1'b1, 1'b1, mk(4'd0, 4'd0, 4'd5, 1'b1, 1'b1));
      waitIdle("busy_fall_5");
      waitCycles(3 * FRAME);
      applyStimulus(8'd40, 1'b1, 1'b1, mk(4'd0, 4'd4, 4'd0, 1'b1, 1'b0));
      waitIdle("busy_fall_40");
      waitCycles(3 * FRAME);

      $display("[TB] last-wins: 200 in flight, then 10 and 20");
      applyStimulus(8'd200, 1'b1, 1'b1, mk(4'd2, 4'd0, 4'd0, 1'b0, 1'b0));
      waitCycles(1);
      applyStimulus(8'd10, 1'b0, 1'b0, none);
      applyStimulus(8'd20, 1'b1, 1'b1, mk(4'd0, 4'd2, 4'd0, 1'b1, 1'b0));
      checkOutput("busy_in_wait", {31'd0, busy}, 1);
      waitIdle("busy_fall_lastwins");
      checkOutput("lastwins_requests_done", exp_conv.size(), 0);
      waitCycles(3 * FRAME);

      $display("[TB] capture on the frame wrap");
      conv_delay = 0;
      applyStimulus(8'd99, 1'b1, 1'b1, mk(4'd0, 4'd9, 4'd9, 1'b1, 1'b0));
      waitCycles(1);
      waitWrapMinus1();
      forceDone(12'h099, 1'b1);
      waitIdle("busy_fall_collision");
      waitCycles(3 * FRAME);

      $display("[TB] non-decimal nibbles pass through");
      applyStimulus(8'd123, 1'b1, 1'b1, mk(4'hA, 4'hB, 4'hC, 1'b0, 1'b0));
      waitCycles(2);
      forceDone(12'hABC, 1'b1);
      waitIdle("busy_fall_passthrough");
      waitCycles(3 * FRAME);

      $display("[TB] spurious conv_done while idle");
      forceDone(12'h321, 1'b0);
      checkOutput("spurious_busy", {31'd0, busy}, 0);
      waitCycles(3 * FRAME);

      $display("[TB] reset during WAIT with a pending value");
      conv_delay = 8;
      applyStimulus(8'd77, 1'b1, 1'b0, none);
      waitCycles(2);
      applyStimulus(8'd88, 1'b0, 1'b0, none);
      checkOutput("busy_before_reset", {31'd0, busy}, 1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkOutput("reset_mid_busy", {31'd0, busy}, 0);
      checkOutput("reset_mid_conv_start", {31'd0, conv_start}, 0);
      checkOutput("reset_mid_select", {29'd0, digit_select}, 32'b001);
      waitCycles(4 * FRAME);
      checkOutput("reset_mid_busy_late", {31'd0, busy}, 0);

      checkOutput("conv_queue_empty", exp_conv.size(), 0);
      checkOutput("disp_queue_empty", disp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
